// File: rtl/dsp_muladd_cascade.sv
// ---------------------------------------------------------------------------
// dsp_muladd_cascade
//   Parametrised multiply-add/accumulate element for a DSP tile column.
//   Q <= (A' * B') + X' + F, wrapped to ACC_WIDTH bits, where
//     A', B', X' : operands, each optionally delayed by one input register
//     X          : C or cascade_in (from the neighbouring tile)
//     F          : Q feedback in accumulate mode, forced to 0 by clr
//   A sticky overflow flag is registered alongside Q.
//
// Ports
//   UserCLK      fabric clock, rising edge
//   rst          asynchronous active-high reset of every register
//   A, B         multiplicand / multiplier
//   C            external addend
//   cascade_in   addend from the neighbouring tile's cascade_out
//   ce           clock enable for every register
//   clr          restart accumulation (qualified by ce)
//   ConfigBits   [0] A_REG [1] B_REG [2] C_REG [3] SIGNED [4] ACC_MODE [5] X_SEL
//   Q            registered result
//   cascade_out  copy of Q for the neighbouring tile
//   ovf          sticky overflow flag
// ---------------------------------------------------------------------------
module dsp_muladd_cascade #(
  parameter int A_WIDTH      = 8,
  parameter int B_WIDTH      = 8,
  parameter int ACC_WIDTH    = 20,
  parameter int NoConfigBits = 6
) (
  input  logic                    UserCLK,
  input  logic                    rst,
  input  logic [A_WIDTH-1:0]      A,
  input  logic [B_WIDTH-1:0]      B,
  input  logic [ACC_WIDTH-1:0]    C,
  input  logic [ACC_WIDTH-1:0]    cascade_in,
  input  logic                    ce,
  input  logic                    clr,
  input  logic [NoConfigBits-1:0] ConfigBits,
  output logic [ACC_WIDTH-1:0]    Q,
  output logic [ACC_WIDTH-1:0]    cascade_out,
  output logic                    ovf
);

  // Two guard bits hold P + X + F exactly in both signed and unsigned mode.
  localparam int EW = ACC_WIDTH + 2;

  generate
    if (ACC_WIDTH < A_WIDTH + B_WIDTH) begin : g_acc_width_check
      $error("dsp_muladd_cascade: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
    end
    if (NoConfigBits < 6) begin : g_cfg_width_check
      $error("dsp_muladd_cascade: NoConfigBits must be >= 6");
    end
  endgenerate

  // Configuration decode
  logic a_reg_s, b_reg_s, c_reg_s, signed_s, acc_mode_s, x_sel_s;
  assign a_reg_s    = ConfigBits[0];
  assign b_reg_s    = ConfigBits[1];
  assign c_reg_s    = ConfigBits[2];
  assign signed_s   = ConfigBits[3];
  assign acc_mode_s = ConfigBits[4];
  assign x_sel_s    = ConfigBits[5];

  // Registers
  logic [A_WIDTH-1:0]   a_q, a_d;
  logic [B_WIDTH-1:0]   b_q, b_d;
  logic [ACC_WIDTH-1:0] x_q, x_d;
  logic [ACC_WIDTH-1:0] q_q, q_d;
  logic                 ovf_q, ovf_d;

  // Datapath signals
  logic [A_WIDTH-1:0]   a_eff_s;
  logic [B_WIDTH-1:0]   b_eff_s;
  logic [ACC_WIDTH-1:0] x_mux_s;
  logic [ACC_WIDTH-1:0] x_eff_s;
  logic [ACC_WIDTH-1:0] f_s;
  logic [EW-1:0]        a_ext_s, b_ext_s, x_ext_s, f_ext_s;
  logic [EW-1:0]        prod_s;
  logic [EW-1:0]        sum_s;
  logic                 ovf_now_s;

  // Operand selection, extension, multiply-add and overflow detection.
  always_comb begin
    a_eff_s   = A;
    b_eff_s   = B;
    x_mux_s   = C;
    x_eff_s   = C;
    f_s       = {ACC_WIDTH{1'b0}};
    a_ext_s   = {EW{1'b0}};
    b_ext_s   = {EW{1'b0}};
    x_ext_s   = {EW{1'b0}};
    f_ext_s   = {EW{1'b0}};
    prod_s    = {EW{1'b0}};
    sum_s     = {EW{1'b0}};
    ovf_now_s = 1'b0;

    if (a_reg_s) a_eff_s = a_q; else a_eff_s = A;
    if (b_reg_s) b_eff_s = b_q; else b_eff_s = B;
    if (x_sel_s) x_mux_s = cascade_in; else x_mux_s = C;
    if (c_reg_s) x_eff_s = x_q; else x_eff_s = x_mux_s;
    if (acc_mode_s && !clr) f_s = q_q; else f_s = {ACC_WIDTH{1'b0}};

    // Extending both factors to EW bits and keeping the low EW bits of the
    // product yields the exact product, since it fits in A_WIDTH+B_WIDTH bits.
    a_ext_s = {{(EW-A_WIDTH){signed_s & a_eff_s[A_WIDTH-1]}}, a_eff_s};
    b_ext_s = {{(EW-B_WIDTH){signed_s & b_eff_s[B_WIDTH-1]}}, b_eff_s};
    x_ext_s = {{2{signed_s & x_eff_s[ACC_WIDTH-1]}}, x_eff_s};
    f_ext_s = {{2{signed_s & f_s[ACC_WIDTH-1]}}, f_s};

    prod_s = a_ext_s * b_ext_s;
    sum_s  = prod_s + x_ext_s + f_ext_s;

    // Signed: result fits only if the guard bits replicate the ACC sign bit.
    if (signed_s) begin
      ovf_now_s = (sum_s[EW-1:ACC_WIDTH-1] != {3{sum_s[EW-1]}});
    end else begin
      ovf_now_s = |sum_s[EW-1:ACC_WIDTH];
    end
  end

  // Next-state: everything holds while ce is low; clr restarts the sticky flag.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    x_d   = x_q;
    q_d   = q_q;
    ovf_d = ovf_q;
    if (ce) begin
      a_d = A;
      b_d = B;
      x_d = x_mux_s;
      q_d = sum_s[ACC_WIDTH-1:0];
      if (clr) begin
        ovf_d = ovf_now_s;
      end else begin
        ovf_d = ovf_q | ovf_now_s;
      end
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst) begin
      a_q   <= {A_WIDTH{1'b0}};
      b_q   <= {B_WIDTH{1'b0}};
      x_q   <= {ACC_WIDTH{1'b0}};
      q_q   <= {ACC_WIDTH{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      x_q   <= x_d;
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q           = q_q;
  assign cascade_out = q_q;
  assign ovf         = ovf_q;

endmodule

// File: doc/dsp_muladd_cascade.md
Name: dsp_muladd_cascade

Overview:
- Parametrised multiply-add/accumulate BEL for the next-generation DSP supertile.
- Generalises the fixed-width DSP slice to configurable operand and accumulator widths.
- Adds optional input pipelining, signed/unsigned mode, an accumulate mode and a sticky overflow flag.
- Adds a registered cascade path, so adjacent DSP tiles in a column chain through the top2bot/bot2top style inter-tile wires.

Parameters:
- A_WIDTH, 8, width of multiplicand A.
- B_WIDTH, 8, width of multiplier B.
- ACC_WIDTH, 20, accumulator/result width; must be >= A_WIDTH+B_WIDTH (elaboration error otherwise).
- NoConfigBits, 6, number of configuration bits consumed.

Ports:
- UserCLK  input  1  fabric user clock; all registers on rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  A_WIDTH  multiplicand.
- B  input  B_WIDTH  multiplier.
- C  input  ACC_WIDTH  external addend.
- cascade_in  input  ACC_WIDTH  addend from the neighbouring DSP's cascade_out.
- ce  input  1  clock enable for every register in the block.
- clr  input  1  synchronous accumulator clear / restart (qualified by ce).
- ConfigBits  input  NoConfigBits  static configuration from the tile's config latches.
- Q  output  ACC_WIDTH  registered result.
- cascade_out  output  ACC_WIDTH  equals Q; routed to the neighbour tile.
- ovf  output  1  sticky overflow flag.

Behaviour:
- Reset and clock: one clock (UserCLK); reset is asynchronous and active-high (rst). While rst=1, all registers are 0 immediately, without waiting for a clock edge: A/B/C input regs, Q, ovf.
- ConfigBits[0] A_REG: 1 = A registered (stage 1); 0 = combinational.
- ConfigBits[1] B_REG: same, for B.
- ConfigBits[2] C_REG: same, for the selected addend.
- ConfigBits[3] SIGNED: 1 = A, B and addend are two's complement; 0 = unsigned.
- ConfigBits[4] ACC_MODE: 1 = add the Q feedback term; 0 = no feedback.
- ConfigBits[5] X_SEL: 0 = addend X is C; 1 = addend X is cascade_in.
- Config changes during operation take effect at the next active edge; no other guarantee.
- Datapath:
  - P = A' * B', width A_WIDTH+B_WIDTH, signed or unsigned per SIGNED.
  - P is sign- or zero-extended to ACC_WIDTH.
  - F = Q if (ACC_MODE and not clr), else 0.
  - S = P + X' + F, computed exactly in ACC_WIDTH+2 bits.
  - Q <= S mod 2^ACC_WIDTH: wrap-around, never saturation.
- Latency from A/B/X presented to Q updated:
  - 1 edge when all enabled-path regs are off.
  - 2 edges when the relevant operand reg is on.
  - Mixed settings give a per-operand latency; the bench must align operands accordingly.
- ce=0: every register, including the input regs, holds its value. clr is ignored.
- clr=1 with ce=1: the feedback term is forced to 0, so Q loads P+X. ovf clears to 0 on the same edge, unless that edge itself overflows, in which case ovf=1.
- Overflow:
  - Unsigned: S >= 2^ACC_WIDTH.
  - Signed: S < -2^(ACC_WIDTH-1) or S > 2^(ACC_WIDTH-1)-1.
  - Once set, ovf stays 1 until a clr edge or rst. It is registered alongside Q.
- cascade_out is Q: registered and glitch-free. There is no combinational path from cascade_in to cascade_out.
- Estimated RTL size: about 150-250 lines.

Test Plan:
- Unsigned, all regs off, ACC_MODE=0, X_SEL=0: A=200, B=100, C=5, ce=1 -> Q=20005 after 1 edge; ovf=0.
- SIGNED=1: A=0xFD (-3), B=7, C=0 -> Q=0xFFFEB (-21, 20 bits). Same inputs with SIGNED=0 -> Q=1771.
- A_REG=B_REG=1, ACC_MODE=1: clr pulse, then A=10, B=10, C=0 held for 5 edges -> Q=100,200,300,400,500, first value 2 edges after presentation. A mid-run ce=0 for 3 cycles -> Q frozen.
- Unsigned accumulate of 255*255=65025:
  - After 16 adds Q=1040400, ovf=0.
  - 17th add -> Q=56849, ovf=1; ovf stays 1 on subsequent adds.
  - clr edge -> Q=65025, ovf=0.
- Two instances chained, second with X_SEL=1:
  - First: A=3, B=4, C=1.
  - Second: A=2, B=5.
  - -> first Q=13; second Q=23 one edge later.
- rst asserted asynchronously between edges mid-accumulation -> Q=0, cascade_out=0, ovf=0 immediately. After release, the first edge with A=1, B=1, C=0 and ACC_MODE=1 -> Q=1.
